// File: rtl/dbus_responder.sv
// Memory-side endpoint of the core data bus. Serves one request at a time
// from a word-addressed 64-bit store and answers after LATENCY cycles.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int          IDX_W    = $clog2(MEM_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_WORDS) * 64'd8;
  localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [63:0] mem [MEM_WORDS];

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             data_ok_q;
  logic [63:0]      rdata_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_q;
  logic [7:0]       strb_q;
  logic [63:0]      wdata_q;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_word;
    for (int i = 0; i < 8; i++)
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    return res;
  endfunction

  logic [63:0]      off;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_in;
  logic             accept;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_en;
  logic [63:0]      rd_word;
  logic             unused_bits;

  assign off     = dreq.addr - BASE_ADDR;
  assign acc_idx = off[IDX_W+2:3];
  assign acc_in  = (dreq.addr >= BASE_ADDR) && (dreq.addr < END_ADDR);
  assign accept  = (state == IDLE) && dreq.valid;
  assign unused_bits = ^{dreq.size, off[2:0], off[63:IDX_W+3]};

  // With single-cycle latency the read happens on the accepting edge, so the
  // live request is used; otherwise the latched one.
  assign rd_idx  = (LATENCY == 1) ? acc_idx : idx_q;
  assign rd_en   = (LATENCY == 1) ? (acc_in && dreq.strobe == 8'd0)
                                  : (in_q && strb_q == 8'd0);
  assign rd_word = rd_en ? mem[rd_idx] : 64'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 64'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            if (!acc_in) err <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              data_ok_q <= 1'b1;
              rdata_q   <= rd_word;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            state     <= RESP;
            cnt       <= 4'd0;
            data_ok_q <= 1'b1;
            rdata_q   <= rd_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          data_ok_q <= 1'b0;
          rdata_q   <= 64'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= acc_idx;
      in_q    <= acc_in;
      strb_q  <= dreq.strobe;
      wdata_q <= dreq.data;
    end
  end

  // Commit only on a clean RESP->IDLE edge; a reset landing here drops it.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && in_q && strb_q != 8'd0)
      mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, strb_q);
  end

  assign dresp.addr_ok = accept;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = rdata_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: three instances at LATENCY 1, 2 and 3
// share clock and reset; vectors carry hand-computed expected values.
module tb_dbus_responder;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  q [3];
  dbus_resp_t r [3];
  logic       e [3];
  int         nvec = 0;
  int         nbad = 0;

  always #5 clk = ~clk;

  dbus_responder #(.LATENCY(1)) u1 (.clk(clk), .reset(reset), .dreq(q[0]), .dresp(r[0]), .err(e[0]));
  dbus_responder #(.LATENCY(2)) u2 (.clk(clk), .reset(reset), .dreq(q[1]), .dresp(r[1]), .err(e[1]));
  dbus_responder #(.LATENCY(3)) u3 (.clk(clk), .reset(reset), .dreq(q[2]), .dresp(r[2]), .err(e[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic dbus_req_t mkreq(input logic [63:0] a, input logic [7:0] s,
                                      input logic [63:0] d);
    dbus_req_t t;
    t.valid  = 1'b1;
    t.addr   = a;
    t.size   = 3'd3;
    t.strobe = s;
    t.data   = d;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at the top of an IDLE cycle, drops valid after the accept cycle,
  // and returns at the top of the IDLE cycle after data_ok.
  task automatic xact(input int u, input logic [63:0] a, input logic [7:0] s,
                      input logic [63:0] d, output logic [63:0] rd, output int lat);
    lat = -1;
    rd  = 64'd0;
    q[u] = mkreq(a, s, d);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (r[u].data_ok) begin
        lat = c;
        rd  = r[u].data;
        tick();
        break;
      end
      tick();
      if (c == 0) q[u].valid = 1'b0;
    end
    q[u].valid = 1'b0;
  endtask

  logic [63:0] rd;
  int          lat;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) q[i] = '0;
    u2.mem[0]    = 64'h1122_3344_5566_7788;
    u2.mem[1]    = 64'd0;
    u2.mem[4095] = 64'hDEAD_BEEF_DEAD_BEEF;
    u1.mem[3]    = 64'hFFFF_FFFF_FFFF_FFFF;
    u3.mem[2]    = 64'h5;
    u3.mem[5]    = 64'd0;

    @(negedge clk);
    chk("rst_data_ok", {63'd0, r[1].data_ok}, 64'd0);
    chk("rst_data",    r[1].data, 64'd0);
    chk("rst_err",     {63'd0, e[1]}, 64'd0);
    chk("rst_addr_ok0", {63'd0, r[1].addr_ok}, 64'd0);
    q[1].valid = 1'b1;
    #1;
    chk("rst_addr_ok1", {63'd0, r[1].addr_ok}, 64'd1);
    q[1].valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // LATENCY=2 read with valid held high throughout
    q[1] = mkreq(64'h8000_0000, 8'h00, 64'd0);
    @(negedge clk);
    chk("rd_c0_addr_ok", {63'd0, r[1].addr_ok}, 64'd1);
    chk("rd_c0_data_ok", {63'd0, r[1].data_ok}, 64'd0);
    tick();
    @(negedge clk);
    chk("rd_c1_addr_ok", {63'd0, r[1].addr_ok}, 64'd0);
    chk("rd_c1_data_ok", {63'd0, r[1].data_ok}, 64'd0);
    tick();
    @(negedge clk);
    chk("rd_c2_data_ok", {63'd0, r[1].data_ok}, 64'd1);
    chk("rd_c2_data",    r[1].data, 64'h1122_3344_5566_7788);
    chk("rd_c2_addr_ok", {63'd0, r[1].addr_ok}, 64'd0);
    tick();
    @(negedge clk);
    chk("rd_c3_addr_ok", {63'd0, r[1].addr_ok}, 64'd1);
    chk("rd_c3_data_ok", {63'd0, r[1].data_ok}, 64'd0);
    chk("rd_c3_data",    r[1].data, 64'd0);
    tick();
    @(negedge clk);
    chk("rd_c4_data_ok", {63'd0, r[1].data_ok}, 64'd0);
    tick();
    @(negedge clk);
    chk("rd_c5_data_ok", {63'd0, r[1].data_ok}, 64'd1);
    chk("rd_c5_data",    r[1].data, 64'h1122_3344_5566_7788);
    tick();
    q[1].valid = 1'b0;

    // strobed write, then read back
    xact(1, 64'h8000_0008, 8'b0000_1100, 64'hAAAA_BBBB_CCCC_DDDD, rd, lat);
    chk("wr_lat",  64'(lat), 64'd2);
    chk("wr_data", rd, 64'd0);
    xact(1, 64'h8000_0008, 8'h00, 64'd0, rd, lat);
    chk("wr_rb",   rd, 64'h0000_0000_CCCC_0000);

    // LATENCY=1 write then read back-to-back
    q[0] = mkreq(64'h8000_0018, 8'hFF, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("l1_c0_addr_ok", {63'd0, r[0].addr_ok}, 64'd1);
    chk("l1_c0_data_ok", {63'd0, r[0].data_ok}, 64'd0);
    tick();
    @(negedge clk);
    chk("l1_c1_data_ok", {63'd0, r[0].data_ok}, 64'd1);
    chk("l1_c1_data",    r[0].data, 64'd0);
    q[0] = mkreq(64'h8000_0018, 8'h00, 64'd0);
    tick();
    @(negedge clk);
    chk("l1_c2_data_ok", {63'd0, r[0].data_ok}, 64'd0);
    chk("l1_c2_addr_ok", {63'd0, r[0].addr_ok}, 64'd1);
    tick();
    q[0].valid = 1'b0;
    @(negedge clk);
    chk("l1_c3_data_ok", {63'd0, r[0].data_ok}, 64'd1);
    chk("l1_c3_data",    r[0].data, 64'h0123_4567_89AB_CDEF);
    tick();

    // out-of-range read and write on the LATENCY=2 instance
    xact(1, 64'h7FFF_FFF8, 8'h00, 64'd0, rd, lat);
    chk("oor_rd_lat",  64'(lat), 64'd2);
    chk("oor_rd_data", rd, 64'd0);
    chk("oor_rd_err",  {63'd0, e[1]}, 64'd1);
    xact(1, 64'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, lat);
    chk("oor_wr_lat",  64'(lat), 64'd2);
    chk("oor_wr_data", rd, 64'd0);
    chk("oor_wr_err",  {63'd0, e[1]}, 64'd1);
    chk("oor_mem0",    u2.mem[0], 64'h1122_3344_5566_7788);
    chk("oor_mem_top", u2.mem[4095], 64'hDEAD_BEEF_DEAD_BEEF);
    tick();
    chk("oor_err_sticky", {63'd0, e[1]}, 64'd1);

    // LATENCY=3 write with valid dropped in cycle 1
    xact(2, 64'h8000_0028, 8'hF0, 64'h1111_2222_3333_4444, rd, lat);
    chk("l3_wr_lat", 64'(lat), 64'd3);
    xact(2, 64'h8000_0028, 8'h00, 64'd0, rd, lat);
    chk("l3_rd_lat",  64'(lat), 64'd3);
    chk("l3_rd_data", rd, 64'h1111_2222_0000_0000);

    // reset pulsed during WAIT of a write to mem[2]
    q[2] = mkreq(64'h8000_0010, 8'hFF, 64'hFFFF_FFFF);
    tick();
    q[2].valid = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    chk("rw_data_ok", {63'd0, r[2].data_ok}, 64'd0);
    chk("rw_data",    r[2].data, 64'd0);
    chk("rw_err2",    {63'd0, e[1]}, 64'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rw_c3_data_ok", {63'd0, r[2].data_ok}, 64'd0);
    tick();
    @(negedge clk);
    chk("rw_c4_data_ok", {63'd0, r[2].data_ok}, 64'd0);
    tick();
    chk("rw_mem2", u3.mem[2], 64'h5);
    xact(2, 64'h8000_0010, 8'h00, 64'd0, rd, lat);
    chk("rw_fresh_lat",  64'(lat), 64'd3);
    chk("rw_fresh_data", rd, 64'h5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
